// File: rtl/pc_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// pc_sequencer_pkg
// Shared definitions for the program-counter sequencer.
//   pc_state_e   : sequencer FSM states (SLOT is only reachable when the
//                  BRANCH_DELAY_SLOT_EN build macro is defined)
//   PC_INCREMENT : byte distance between consecutive instruction words
//   WORD_SHIFT   : shift converting a word offset/index into a byte address
// ---------------------------------------------------------------------------
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        RUN    = 2'd1,
        SLOT   = 2'd2,
        HALTED = 2'd3
    } pc_state_e;

    localparam int PC_INCREMENT = 4;
    localparam int WORD_SHIFT   = 2;

endpackage

// File: rtl/pc_sequencer_target_calc.sv
// ---------------------------------------------------------------------------
// branch_target_calc
// Purely combinational next-address arithmetic for the PC sequencer.
// Ports:
//   i_pc            : current fetch address
//   i_imm_se        : sign-extended branch offset, in words
//   i_jump_index    : 26-bit jump instruction index field
//   o_pc_plus4      : i_pc + 4
//   o_branch_target : o_pc_plus4 + (i_imm_se << 2)
//   o_jump_target   : {o_pc_plus4[top:28], i_jump_index, 2'b00}
// All sums wrap modulo 2^PC_WIDTH. PC_WIDTH must exceed 28 so that the
// jump region bits above the index field exist.
// ---------------------------------------------------------------------------
module branch_target_calc
    import pc_sequencer_pkg::*;
#(
    parameter int PC_WIDTH = 32
) (
    input  logic [PC_WIDTH-1:0] i_pc,
    input  logic [PC_WIDTH-1:0] i_imm_se,
    input  logic [25:0]         i_jump_index,
    output logic [PC_WIDTH-1:0] o_pc_plus4,
    output logic [PC_WIDTH-1:0] o_branch_target,
    output logic [PC_WIDTH-1:0] o_jump_target
);

    logic [PC_WIDTH-1:0] w_pc_plus4;

    assign w_pc_plus4      = i_pc + PC_WIDTH'(PC_INCREMENT);
    assign o_pc_plus4      = w_pc_plus4;
    assign o_branch_target = w_pc_plus4 + (i_imm_se << WORD_SHIFT);
    // Jumps stay inside the region selected by the upper bits of PC+4.
    assign o_jump_target   = {w_pc_plus4[PC_WIDTH-1:28], i_jump_index, {WORD_SHIFT{1'b0}}};

endmodule

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
// Program-counter sequencer: INIT -> RUN, redirects on jump / taken branch,
// stalls, and a sticky HALTED state left only through RST.
// Build option: BRANCH_DELAY_SLOT_EN adds a SLOT state and a pending-target
// register so a redirect first fetches the delay slot (PC+4), then the target.
// Ports:
//   CLK, RST   : clock, synchronous active-high reset
//   Stall      : hold PC and all state this cycle
//   Branch     : conditional branch; taken when Branch & Zero
//   Zero       : ALU zero flag
//   Jump       : absolute jump
//   Halt       : stop fetching
//   Imm_SE     : sign-extended branch word offset
//   Jump_Index : jump index field
//   PC         : current fetch address (registered)
//   PC_Valid   : PC is fetchable this cycle (registered)
//   Halted     : sequencer stopped (registered)
//   Dbg_State  : current FSM state, for observation only
// ---------------------------------------------------------------------------
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int                  PC_WIDTH     = 32,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = PC_WIDTH'(32'h0000_0000)
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                Stall,
    input  logic                Branch,
    input  logic                Zero,
    input  logic                Jump,
    input  logic                Halt,
    input  logic [PC_WIDTH-1:0] Imm_SE,
    input  logic [25:0]         Jump_Index,
    output logic [PC_WIDTH-1:0] PC,
    output logic                PC_Valid,
    output logic                Halted,
    output logic [1:0]          Dbg_State
);

    // Low address bits are forced to zero so PC is always word aligned.
    localparam logic [PC_WIDTH-1:0] RESET_PC = {RESET_VECTOR[PC_WIDTH-1:WORD_SHIFT], {WORD_SHIFT{1'b0}}};

    pc_state_e           r_state;
    logic [PC_WIDTH-1:0] r_pc;
    logic                r_pc_valid;
    logic                r_halted;
`ifdef BRANCH_DELAY_SLOT_EN
    logic [PC_WIDTH-1:0] r_pending;
`endif

    logic [PC_WIDTH-1:0] w_pc_plus4;
    logic [PC_WIDTH-1:0] w_branch_target;
    logic [PC_WIDTH-1:0] w_jump_target;
    logic                w_redirect;
    logic [PC_WIDTH-1:0] w_redirect_target;

    branch_target_calc #(
        .PC_WIDTH (PC_WIDTH)
    ) u_target_calc (
        .i_pc            (r_pc),
        .i_imm_se        (Imm_SE),
        .i_jump_index    (Jump_Index),
        .o_pc_plus4      (w_pc_plus4),
        .o_branch_target (w_branch_target),
        .o_jump_target   (w_jump_target)
    );

    // Jump outranks a taken branch when both are presented.
    assign w_redirect        = Jump | (Branch & Zero);
    assign w_redirect_target = Jump ? w_jump_target : w_branch_target;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= INIT;
            r_pc       <= RESET_PC;
            r_pc_valid <= 1'b0;
            r_halted   <= 1'b0;
`ifdef BRANCH_DELAY_SLOT_EN
            r_pending  <= '0;
`endif
        end else begin
            case (r_state)
                INIT: begin
                    // Leaves INIT after one cycle regardless of Stall.
                    r_state    <= RUN;
                    r_pc_valid <= 1'b1;
                end
                RUN: begin
                    if (!Stall) begin
                        if (Halt) begin
                            r_state    <= HALTED;
                            r_pc_valid <= 1'b0;
                            r_halted   <= 1'b1;
                        end else if (w_redirect) begin
`ifdef BRANCH_DELAY_SLOT_EN
                            r_pending <= w_redirect_target;
                            r_pc      <= w_pc_plus4;
                            r_state   <= SLOT;
`else
                            r_pc <= w_redirect_target;
`endif
                        end else begin
                            r_pc <= w_pc_plus4;
                        end
                    end
                end
`ifdef BRANCH_DELAY_SLOT_EN
                SLOT: begin
                    // Branch/Jump are ignored here; Halt drops the pending target.
                    if (!Stall) begin
                        if (Halt) begin
                            r_state    <= HALTED;
                            r_pc_valid <= 1'b0;
                            r_halted   <= 1'b1;
                            r_pending  <= '0;
                        end else begin
                            r_pc    <= r_pending;
                            r_state <= RUN;
                        end
                    end
                end
`endif
                HALTED: begin
                    // Frozen until RST.
                end
                default: begin
                    r_state    <= INIT;
                    r_pc       <= RESET_PC;
                    r_pc_valid <= 1'b0;
                    r_halted   <= 1'b0;
                end
            endcase
        end
    end

    assign PC        = r_pc;
    assign PC_Valid  = r_pc_valid;
    assign Halted    = r_halted;
    assign Dbg_State = r_state;

endmodule

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer
// Table-driven bench for pc_sequencer. Each record holds one cycle of inputs
// and the PC / PC_Valid / Halted expected after the following rising edge.
// Expected outputs go into exp_q when a cycle is driven and are popped when
// the outputs are sampled 1 time unit after the edge.
// Define BRANCH_DELAY_SLOT_EN for both bench and RTL to run the delay-slot table.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;
    import pc_sequencer_pkg::*;

    localparam int PC_WIDTH = 32;
    localparam int W        = PC_WIDTH + 2;

    // ---------------- clock / reset / DUT ----------------
    logic                CLK = 1'b0;
    logic                RST;
    logic                Stall, Branch, Zero, Jump, Halt;
    logic [PC_WIDTH-1:0] Imm_SE;
    logic [25:0]         Jump_Index;
    logic [PC_WIDTH-1:0] PC;
    logic                PC_Valid;
    logic                Halted;
    logic [1:0]          Dbg_State;

    always #5 CLK = ~CLK;

    pc_sequencer #(
        .PC_WIDTH     (PC_WIDTH),
        .RESET_VECTOR (32'h0000_0000)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .Stall      (Stall),
        .Branch     (Branch),
        .Zero       (Zero),
        .Jump       (Jump),
        .Halt       (Halt),
        .Imm_SE     (Imm_SE),
        .Jump_Index (Jump_Index),
        .PC         (PC),
        .PC_Valid   (PC_Valid),
        .Halted     (Halted),
        .Dbg_State  (Dbg_State)
    );

    // ---------------- vectors and scoreboard ----------------
    typedef struct {
        logic                rst, stall, branch, zero, jump, halt;
        logic [PC_WIDTH-1:0] imm;
        logic [25:0]         jidx;
        logic [PC_WIDTH-1:0] exp_pc;
        logic                exp_valid, exp_halted;
    } vec_t;

    vec_t           vecs[$];
    logic [W-1:0]   exp_q[$];
    int             tests_run    = 0;
    int             tests_failed = 0;

    function automatic vec_t mk(input logic rst, stall, branch, zero, jump, halt,
                                input logic [PC_WIDTH-1:0] imm, input logic [25:0] jidx,
                                input logic [PC_WIDTH-1:0] exp_pc,
                                input logic exp_valid, exp_halted);
        vec_t v;
        v.rst = rst; v.stall = stall; v.branch = branch; v.zero = zero;
        v.jump = jump; v.halt = halt; v.imm = imm; v.jidx = jidx;
        v.exp_pc = exp_pc; v.exp_valid = exp_valid; v.exp_halted = exp_halted;
        return v;
    endfunction

    task automatic check_out(input string name);
        logic [W-1:0] exp;
        logic [W-1:0] got;
        tests_run++;
        if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL %s: output sampled with no expectation queued", name);
        end else begin
            exp = exp_q.pop_front();
            got = {PC, PC_Valid, Halted};
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL %s: got pc=%h valid=%b halted=%b, expected pc=%h valid=%b halted=%b",
                         name, got[W-1:2], got[1], got[0], exp[W-1:2], exp[1], exp[0]);
            end
        end
        tests_run++;
        if (PC[1:0] !== 2'b00) begin
            tests_failed++;
            $display("FAIL %s_align: got pc[1:0]=%b, expected 00", name, PC[1:0]);
        end
    endtask

    // Drive one cycle of inputs, queue the expectation, sample after the edge.
    task automatic drive(input vec_t v, input string name);
        RST = v.rst; Stall = v.stall; Branch = v.branch; Zero = v.zero;
        Jump = v.jump; Halt = v.halt; Imm_SE = v.imm; Jump_Index = v.jidx;
        exp_q.push_back({v.exp_pc, v.exp_valid, v.exp_halted});
        @(posedge CLK);
        #1;
        check_out(name);
    endtask

    // ---------------- test ----------------
    initial begin
        logic [PC_WIDTH-1:0] halted_pc;
        vec_t                v;

        RST = 1'b1; Stall = 1'b0; Branch = 1'b0; Zero = 1'b0;
        Jump = 1'b0; Halt = 1'b0; Imm_SE = '0; Jump_Index = '0;

        //                rst stl brn zer jmp hlt imm           jidx        exp_pc        v  h
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0,        26'h0,       32'h0000_0000, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0,        26'h0,       32'h0000_0000, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        26'h0,       32'h0000_0000, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        26'h0,       32'h0000_0004, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        26'h0,       32'h0000_0008, 1, 0));
`ifndef BRANCH_DELAY_SLOT_EN
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 32'h0,        26'h0,       32'h0000_0008, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 0, 32'h0,        26'h5,       32'h0000_0008, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 32'h0,        26'h0,       32'h0000_0008, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        26'h0,       32'h0000_000C, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        26'h0,       32'h0000_0010, 1, 0));
        // taken backward branch 0x10 -> 0x04
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 32'hFFFF_FFFC, 26'h0,      32'h0000_0004, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        26'h0,       32'h0000_0008, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        26'h0,       32'h0000_000C, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        26'h0,       32'h0000_0010, 1, 0));
        // not-taken branch falls through to 0x14
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 32'hFFFF_FFFC, 26'h0,      32'h0000_0014, 1, 0));
        // 0x18 + 0xF000_0008 = 0xF000_0020
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 32'h3C00_0002, 26'h0,      32'hF000_0020, 1, 0));
        // jump and taken branch together: jump wins
        vecs.push_back(mk(0, 0, 1, 1, 1, 0, 32'hFFFF_FFFC, 26'h0000100, 32'hF000_0400, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 32'h0,        26'h3FF_FFFF, 32'hFFFF_FFFC, 1, 0));
        // PC+4 wraps to zero
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        26'h0,       32'h0000_0000, 1, 0));
        // Zero without Branch is sequential
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 32'h0000_0040, 26'h0,      32'h0000_0004, 1, 0));
        // Halt outranks Jump, PC held
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 32'h0,        26'h0000100, 32'h0000_0004, 0, 1));
`else
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        26'h0,       32'h0000_000C, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        26'h0,       32'h0000_0010, 1, 0));
        // taken branch at 0x10 to 0x40: delay slot 0x14 first
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 32'h0000_000B, 26'h0,      32'h0000_0014, 1, 0));
        // branch presented in SLOT is ignored
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 32'h0000_0100, 26'h0,      32'h0000_0040, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        26'h0,       32'h0000_0044, 1, 0));
        // jump to 0x80 via slot 0x48, stalled once in SLOT
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 32'h0,        26'h20,      32'h0000_0048, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 32'h0,        26'h0,       32'h0000_0048, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        26'h0,       32'h0000_0080, 1, 0));
        // taken branch, then RST while in SLOT loses the pending target
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 32'h0000_0010, 26'h0,      32'h0000_0084, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0,        26'h0,       32'h0000_0000, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        26'h0,       32'h0000_0000, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        26'h0,       32'h0000_0004, 1, 0));
        // jump into SLOT, then Halt in SLOT
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 32'h0,        26'h40,      32'h0000_0008, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'h0,        26'h0,       32'h0000_0008, 0, 1));
`endif

        foreach (vecs[i]) drive(vecs[i], $sformatf("vec%0d", i));
        halted_pc = vecs[vecs.size()-1].exp_pc;

        // HALTED ignores every input except RST for 10 cycles
        for (int k = 0; k < 10; k++) begin
            v = mk(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), PC_WIDTH'($urandom()),
                   26'($urandom()), halted_pc, 0, 1);
            drive(v, $sformatf("halted%0d", k));
            tests_run++;
            if (Dbg_State !== 2'(HALTED)) begin
                tests_failed++;
                $display("FAIL halted_state%0d: got state=%0d, expected %0d", k, Dbg_State, HALTED);
            end
        end

        // RST leaves HALTED and overrides Stall/Halt
        drive(mk(1, 1, 0, 0, 0, 1, 32'h0, 26'h0, 32'h0000_0000, 0, 0), "rst_from_halted");
        drive(mk(0, 1, 0, 0, 0, 0, 32'h0, 26'h0, 32'h0000_0000, 1, 0), "init_ignores_stall");
        drive(mk(0, 0, 0, 0, 0, 0, 32'h0, 26'h0, 32'h0000_0004, 1, 0), "run_after_rst");
        drive(mk(1, 1, 1, 1, 1, 1, 32'h0, 26'h1, 32'h0000_0000, 0, 0), "rst_in_run");
        drive(mk(0, 0, 0, 0, 0, 0, 32'h0, 26'h0, 32'h0000_0000, 1, 0), "first_valid");
        drive(mk(0, 0, 0, 0, 0, 0, 32'h0, 26'h0, 32'h0000_0004, 1, 0), "second_valid");

        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL drain: got %0d entries left, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
